// File: rtl/data_mem_ctrl.sv
// rtl/data_mem_ctrl.sv - RV32I data-memory controller with sub-word RMW stores

module data_mem_ctrl #(
    parameter int    DEPTH_WORDS = 1024,
    parameter string INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [13:0] addr,
    input  logic [31:0] wr_data,
    input  logic        memwrite,
    input  logic        memread,
    input  logic [2:0]  sign_mask,
    output logic [31:0] read_data,
    output logic        stall,
    output logic [7:0]  led
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_RMW_RD,
        S_WRITE,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [13:0] addr_q;
    logic [31:0] wdata_q;
    logic [2:0]  mask_q;
    logic [31:0] merge_q;
    logic [31:0] ram_q;
    logic [31:0] read_data_q;
    logic        stall_q;
    logic [7:0]  led_val;
    logic        is_led;

    logic [31:0] mem [DEPTH_WORDS];

    logic [IDX_W-1:0] rd_idx, wr_idx;
    assign rd_idx = (state_q == S_IDLE) ? addr[IDX_W+1:2] : addr_q[IDX_W+1:2];
    assign wr_idx = addr_q[IDX_W+1:2];

    logic [31:0] merged, wr_word;
    always_comb begin
        merged = merge_q;
        case (mask_q[1:0])
            2'b00:   merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
            2'b01:   if (addr_q[1]) merged[31:16] = wdata_q[15:0];
                     else           merged[15:0]  = wdata_q[15:0];
            default: merged = wdata_q;
        endcase
    end
    assign wr_word = mask_q[1] ? wdata_q : merged;

    logic [31:0] src, load_v;
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    always_comb begin
        src    = is_led ? {24'h0, led_val} : ram_q;
        byte_v = src[{addr_q[1:0], 3'b000} +: 8];
        half_v = addr_q[1] ? src[31:16] : src[15:0];
        case (mask_q[1:0])
            2'b00:   load_v = {{24{mask_q[2] & byte_v[7]}}, byte_v};
            2'b01:   load_v = {{16{mask_q[2] & half_v[15]}}, half_v};
            default: load_v = src;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (memread)       state_d = S_READ;
                else if (memwrite) state_d = sign_mask[1] ? S_WRITE : S_RMW_RD;
            end
            S_READ:   state_d = S_DONE;
            S_RMW_RD: state_d = S_WRITE;
            S_WRITE:  state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            stall_q     <= 1'b0;
            read_data_q <= 32'h0;
        end else begin
            state_q <= state_d;
            stall_q <= (state_d == S_READ) || (state_d == S_RMW_RD) || (state_d == S_WRITE);
            if (state_q == S_IDLE) begin
                addr_q  <= addr;
                wdata_q <= wr_data;
                mask_q  <= sign_mask;
            end
            if (state_q == S_RMW_RD) merge_q <= ram_q;
            if (state_q == S_READ)   read_data_q <= load_v;
        end
    end

    always_ff @(posedge clk) begin
        ram_q <= mem[rd_idx];
        if (state_q == S_WRITE && !rst && !is_led) mem[wr_idx] <= wr_word;
    end

`ifdef DATA_MEM_LED_MMIO_EN
    logic [7:0] led_q;
    assign is_led  = (addr_q[13:2] == 12'h800);
    assign led_val = led_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            led_q <= 8'h00;
        end else if (state_q == S_WRITE && is_led &&
                     (mask_q[1] || (mask_q[0] ? !addr_q[1] : (addr_q[1:0] == 2'b00)))) begin
            led_q <= wdata_q[7:0];
        end
    end
`else
    logic unused_addr_hi;
    assign is_led         = 1'b0;
    assign led_val        = 8'h00;
    assign unused_addr_hi = ^addr_q;
`endif

    assign read_data = read_data_q;
    assign stall     = stall_q;
    assign led       = led_val;

endmodule
